// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_unit_pkg
// Desc   : Shared fetch-stage state encoding and reset-address default.
// Rev    : 1.0  initial release
// ============================================================================
package instr_fetch_unit_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t c_ST_IDLE = 2'd0;
    localparam fetch_state_t c_ST_WAIT = 2'd1;
    localparam fetch_state_t c_ST_HOLD = 2'd2;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : fetch_skid_buf
// Desc   : One-entry data+valid holding register with load/drain/flush.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         i_load,
    input  logic         i_drain,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    logic [W-1:0] r_data;
    logic         r_valid;

    // Flush outranks load so a squashed entry can never be revived.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_unit
// Desc   : Fetch address generator with 1-cycle SRAM tracking, skid, redirect.
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(c_RESET_PC)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              enable,
    input  logic              stall,
    input  logic              redirect,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] imem_addr,
    output logic              imem_ren,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [DATA_W-1:0] if_pc_plus4,
    output logic              misalign_err,
    output logic [31:0]       fetch_count
);

    fetch_state_t      r_state;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_resp_pc4;
    logic              r_misalign;
    logic [31:0]       r_fetch_count;

    logic              w_go;
    logic              w_in_wait;
    logic              w_in_hold;
    logic              w_issue;
    logic              w_deliver;
    logic [DATA_W-1:0] w_pc_plus4;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_skid_valid;

    assign w_go       = enable & ~stall;
    assign w_in_wait  = (r_state == c_ST_WAIT);
    assign w_in_hold  = (r_state == c_ST_HOLD);
    assign w_issue    = ~redirect & w_go;
    assign w_pc_plus4 = r_pc + DATA_W'(4);

    assign if_valid  = (w_in_wait | w_in_hold) & ~redirect;
    assign w_deliver = if_valid & w_go;

    fetch_skid_buf #(
        .W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .arst    (arst),
        .i_load  (w_in_wait & ~redirect & ~w_go),
        .i_drain (w_in_hold & w_issue),
        .i_flush (redirect),
        .i_data  (imem_rdata),
        .o_data  (w_skid_data),
        .o_valid (w_skid_valid)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state       <= c_ST_IDLE;
            r_pc          <= RESET_PC;
            r_resp_pc4    <= '0;
            r_misalign    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            if (redirect) begin
                r_state <= c_ST_IDLE;
                r_pc    <= {redirect_pc[DATA_W-1:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end else if (w_go) begin
                r_state    <= c_ST_WAIT;
                r_pc       <= w_pc_plus4;
                r_resp_pc4 <= w_pc_plus4;
            end else if (w_in_wait) begin
                r_state <= c_ST_HOLD;
            end

            if (w_deliver) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    // Strobe is masked by reset directly so no read escapes while arst is high.
    assign imem_ren     = w_issue & ~arst;
    assign imem_addr    = r_pc;
    assign if_instr     = w_skid_valid ? w_skid_data
                        : (w_in_wait ? imem_rdata : '0);
    assign if_pc_plus4  = r_resp_pc4;
    assign misalign_err = r_misalign;
    assign fetch_count  = r_fetch_count;

endmodule
`default_nettype wire
